axi_lite_write_resp_slave: RTL and testbench
============================================

Name: axi_lite_write_resp_slave

Overview:
Slave-side consumer of the AXI4-Lite write-data channel. Accepts one write-address beat (AW) and one write-data beat (W), in either order, and applies the strobe-masked write to a register-bank write port. Then returns the write response on the B channel. Sits directly downstream of the write-data channel stage, between the interconnect and the peripheral register file.

Parameters:
ADDR_WIDTH, 32, width of AWADDR
DATA_WIDTH, 32, width of WDATA/reg_wr_data; must be 32 (4 byte lanes)
NUM_REGS, 16, number of 32-bit registers decoded; word index >= NUM_REGS gives SLVERR

Ports:
ACLK  input  1  clock, all logic on rising edge
ARESET  input  1  asynchronous, active-high reset
AWVALID  input  1  address valid
AWREADY  output  1  address ready
AWADDR  input  ADDR_WIDTH  byte address
WVALID  input  1  data valid
WREADY  output  1  data ready
WDATA  input  DATA_WIDTH  write data
WSTRB  input  4  byte-lane strobes
BVALID  output  1  response valid
BREADY  input  1  response ready
BRESP  output  2  00 OKAY, 10 SLVERR
reg_wr_en  output  1  single-cycle write pulse to register bank
reg_wr_idx  output  ADDR_WIDTH-2  word index (AWADDR[ADDR_WIDTH-1:2])
reg_wr_data  output  DATA_WIDTH  WDATA with disabled byte lanes forced to 0
reg_wr_strb  output  4  captured WSTRB

Behaviour:
- Reset (asynchronous, while ARESET=1): AWREADY=0, WREADY=0, BVALID=0, BRESP=00, reg_wr_en=0, reg_wr_idx=0, reg_wr_data=0, reg_wr_strb=0. Capture flags are cleared and the state is COLLECT.
- Assertion of ARESET mid-transaction drops the transaction. No write pulse and no response are issued.
- The first rising edge after ARESET falls sets AWREADY=1 and WREADY=1.
- All outputs are registered.
- States:
  - COLLECT: an AW handshake (AWVALID&AWREADY at an edge) captures AWADDR, sets aw_full and clears AWREADY at that edge. A W handshake captures WDATA and WSTRB, sets w_full and clears WREADY. Both handshakes may occur on the same edge. When both flags are set (including the case where both are set on the same edge), the next state is WRITE.
  - WRITE (exactly 1 cycle):
    - If idx < NUM_REGS and WSTRB != 0: reg_wr_en=1 for this cycle, with reg_wr_idx, reg_wr_data and reg_wr_strb valid in the same cycle. BRESP is set to OKAY.
    - If idx < NUM_REGS and WSTRB == 0: reg_wr_en stays 0 and BRESP is OKAY.
    - If idx >= NUM_REGS: reg_wr_en stays 0 and BRESP is SLVERR.
    - Next state is RESP.
  - RESP: BVALID=1 with BRESP stable until BVALID&BREADY at an edge. At that edge: BVALID goes to 0, both flags are cleared, AWREADY and WREADY go to 1, and the next state is COLLECT.
- AWADDR[1:0] are ignored (no alignment error).
- Latency: with both handshakes at edge t, reg_wr_en is high in cycle t+1 and BVALID is high from cycle t+2. With BREADY already high, the ready signals return in cycle t+3.
- BVALID never depends on BREADY. Once asserted, BVALID holds until the handshake.
- Back-pressure:
  - AW arriving first leaves WREADY=1 and AWREADY=0 until the response completes; the mirror case applies when W arrives first.
  - A second AW offered while aw_full is set is not accepted.
- Byte masking: reg_wr_data[8k+7:8k] = WDATA[8k+7:8k] if WSTRB[k], else 0, for k = 0..3. Any strobe pattern is legal, including non-contiguous patterns.
- reg_wr_en is 0 in every state except WRITE. reg_wr_idx, reg_wr_data and reg_wr_strb hold their last value outside WRITE.

Decomposition:
- Shared package axi_lite_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - The state encoding: COLLECT, WRITE, RESP.
- One sub-module, axi_lite_strb_mask: combinational WDATA/WSTRB byte-lane mask. It is reusable by the master side.

Test Plan:
- Simultaneous AW+W: AWADDR=0x08, WDATA=0xDEADBEEF, WSTRB=1111, BREADY=1 → reg_wr_en pulse 1 cycle later, idx=2, data=0xDEADBEEF. BVALID the next cycle with BRESP=00. AWREADY/WREADY return 1 the following cycle.
- W three cycles before AW: WSTRB=0101, WDATA=0x11223344, AWADDR=0x3C → WREADY low after the W handshake. After the AW handshake, reg_wr_data=0x00220044 and idx=15, followed by OKAY.
- Out-of-range AWADDR=0x40 with NUM_REGS=16 → no reg_wr_en pulse. BRESP=10 with BVALID held for 5 cycles while BREADY=0, then cleared one edge after BREADY=1.
- WSTRB=0000 at AWADDR=0x04 → no reg_wr_en pulse and BRESP=00.
- Back-to-back: second AW/W presented during RESP → not accepted until the cycle after the B handshake. Two distinct writes occur in order.
- Assert ARESET during RESP and during WRITE-pending → all outputs 0 immediately. No reg_wr_en pulse, no BVALID after release. AWREADY/WREADY=1 one edge after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the write-slave state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    RESP    = 2'd2
  } state_t;

endpackage

// File: rtl/axi_lite_strb_mask.sv
// Byte-lane mask: disabled strobe lanes are forced to zero. Shared with the master side.
module axi_lite_strb_mask #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   masked
);

  // Pass each byte lane through only when its strobe is set.
  always_comb begin
    masked = '0;
    for (int k = 0; k < DATA_WIDTH/8; k++) begin
      if (strb[k]) masked[8*k +: 8] = data[8*k +: 8];
    end
  end

endmodule

// File: rtl/axi_lite_write_resp_slave.sv
// AXI4-Lite write slave: collects AW and W in either order, drives a one-cycle
// strobe-masked register write, then returns the B response.
//
// state   | meaning
// COLLECT | waiting for AW and/or W handshakes; ready held low on a captured side
// WRITE   | one cycle; reg_wr_en pulses here when the index is valid and strobes non-zero
// RESP    | BVALID held with stable BRESP until BREADY
module axi_lite_write_resp_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [3:0]            WSTRB,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [1:0]            BRESP,
  output logic                  reg_wr_en,
  output logic [ADDR_WIDTH-3:0] reg_wr_idx,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [3:0]            reg_wr_strb
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] NUM_REGS_IDX = IDX_W'(NUM_REGS);

  state_t                  state;
  logic                    aw_full;
  logic                    w_full;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [3:0]              strb_q;
  logic [DATA_WIDTH-1:0]   masked_data;
  logic                    aw_hs;
  logic                    w_hs;
  logic [IDX_W-1:0]        nxt_idx;
  logic [DATA_WIDTH-1:0]   nxt_data;
  logic [3:0]              nxt_strb;
  logic                    unused_addr_lsbs;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;

  // The write is launched on the edge that completes collection, so use the
  // beat being accepted on that edge in preference to the captured copy.
  assign nxt_idx  = aw_hs ? AWADDR[ADDR_WIDTH-1:2] : idx_q;
  assign nxt_data = w_hs  ? masked_data : data_q;
  assign nxt_strb = w_hs  ? WSTRB : strb_q;

  // Byte offset within the word carries no meaning here; no alignment error.
  assign unused_addr_lsbs = ^AWADDR[1:0];

  axi_lite_strb_mask #(.DATA_WIDTH(DATA_WIDTH)) u_strb_mask (
    .data   (WDATA),
    .strb   (WSTRB),
    .masked (masked_data)
  );

  // Collect / write / respond sequencing with all outputs registered.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= COLLECT;
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      idx_q       <= '0;
      data_q      <= '0;
      strb_q      <= '0;
      AWREADY     <= 1'b0;
      WREADY      <= 1'b0;
      BVALID      <= 1'b0;
      BRESP       <= RESP_OKAY;
      reg_wr_en   <= 1'b0;
      reg_wr_idx  <= '0;
      reg_wr_data <= '0;
      reg_wr_strb <= '0;
    end else begin
      reg_wr_en <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (aw_hs) begin
            idx_q   <= AWADDR[ADDR_WIDTH-1:2];
            aw_full <= 1'b1;
          end
          if (w_hs) begin
            data_q <= masked_data;
            strb_q <= WSTRB;
            w_full <= 1'b1;
          end
          // Also raises both readies on the first edge out of reset.
          AWREADY <= ~(aw_full | aw_hs);
          WREADY  <= ~(w_full | w_hs);
          if ((aw_full | aw_hs) && (w_full | w_hs)) begin
            state <= WRITE;
            if (nxt_idx < NUM_REGS_IDX && nxt_strb != 4'b0000) begin
              reg_wr_en   <= 1'b1;
              reg_wr_idx  <= nxt_idx;
              reg_wr_data <= nxt_data;
              reg_wr_strb <= nxt_strb;
            end
          end
        end
        WRITE: begin
          BRESP  <= (idx_q < NUM_REGS_IDX) ? RESP_OKAY : RESP_SLVERR;
          BVALID <= 1'b1;
          state  <= RESP;
        end
        RESP: begin
          if (BVALID && BREADY) begin
            BVALID  <= 1'b0;
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
            state   <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_write_resp_slave.sv
// Scoreboard bench for axi_lite_write_resp_slave: drivers push expected writes and
// responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_axi_lite_write_resp_slave;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] AWADDR = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [1:0]  BRESP;
  logic        reg_wr_en;
  logic [29:0] reg_wr_idx;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;

  axi_lite_write_resp_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .AWVALID     (AWVALID),
    .AWREADY     (AWREADY),
    .AWADDR      (AWADDR),
    .WVALID      (WVALID),
    .WREADY      (WREADY),
    .WDATA       (WDATA),
    .WSTRB       (WSTRB),
    .BVALID      (BVALID),
    .BREADY      (BREADY),
    .BRESP       (BRESP),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_idx  (reg_wr_idx),
    .reg_wr_data (reg_wr_data),
    .reg_wr_strb (reg_wr_strb)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [29:0] idx;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t        wr_q[$];
  logic [1:0] resp_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: word index = byte address / 4, 16 registers, masked bytes.
  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] idx;
    logic [31:0] masked;
    wr_t         w;
    idx = addr / 4;
    masked = 32'h0;
    for (int k = 0; k < 4; k++)
      if (strb[k]) masked = masked | (data & (32'hFF << (8 * k)));
    if (idx < 16 && strb != 4'b0000) begin
      w.idx = idx[29:0];
      w.data = masked;
      w.strb = strb;
      wr_q.push_back(w);
    end
    resp_q.push_back(idx < 16 ? 2'b00 : 2'b10);
  endtask

  // Monitor: reset values, ready rules, BVALID stability, scoreboard pops.
  int         aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  bit         first_after_rst = 1'b1;
  bit         prev_bv = 1'b0, prev_bhs = 1'b0;
  logic [1:0] prev_bresp = 2'b00;

  always @(negedge ACLK) begin
    if (ARESET) begin
      chk("rst_outputs", {AWREADY, WREADY, BVALID, BRESP, reg_wr_en, reg_wr_idx, reg_wr_data, reg_wr_strb}, 0);
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      first_after_rst = 1'b1;
      prev_bv = 1'b0; prev_bhs = 1'b0;
    end else begin
      if (first_after_rst) begin
        chk("ready_low_before_first_edge", {AWREADY, WREADY}, 2'b00);
        first_after_rst = 1'b0;
      end else begin
        chk("awready_rule", AWREADY, aw_cnt == b_cnt);
        chk("wready_rule", WREADY, w_cnt == b_cnt);
      end
      if (prev_bv && !prev_bhs) chk("bvalid_hold", {BVALID, BRESP}, {1'b1, prev_bresp});
      if (reg_wr_en) begin
        if (wr_q.size() == 0) chk("unexpected_wr_en", 1, 0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("reg_write", {reg_wr_idx, reg_wr_data, reg_wr_strb}, {w.idx, w.data, w.strb});
        end
      end
      if (BVALID && BREADY) begin
        if (resp_q.size() == 0) chk("unexpected_bresp", 1, 0);
        else chk("bresp", BRESP, resp_q.pop_front());
      end
      prev_bv = BVALID;
      prev_bhs = BVALID && BREADY;
      prev_bresp = BRESP;
      if (AWVALID && AWREADY) aw_cnt++;
      if (WVALID && WREADY) w_cnt++;
      if (BVALID && BREADY) b_cnt++;
    end
  end

  // Called at posedge+1; returns at posedge+1 after both handshakes (and B if asked).
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input bit wait_resp, input int bready_pct);
    expect_write(addr, data, strb);
    fork
      begin
        bit got;
        got = 1'b0;
        repeat (aw_dly) begin @(posedge ACLK); #1; end
        AWVALID = 1'b1; AWADDR = addr;
        for (int i = 0; i < 200 && !got; i++) begin
          logic r;
          @(negedge ACLK); r = AWREADY;
          @(posedge ACLK); #1; got = r;
        end
        AWVALID = 1'b0;
        chk("aw_handshake", got, 1);
      end
      begin
        bit got;
        got = 1'b0;
        repeat (w_dly) begin @(posedge ACLK); #1; end
        WVALID = 1'b1; WDATA = data; WSTRB = strb;
        for (int i = 0; i < 200 && !got; i++) begin
          logic r;
          @(negedge ACLK); r = WREADY;
          @(posedge ACLK); #1; got = r;
        end
        WVALID = 1'b0;
        chk("w_handshake", got, 1);
      end
    join
    if (wait_resp) begin
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
        BREADY = ($urandom_range(99) < bready_pct);
        @(negedge ACLK); done = BVALID && BREADY;
        @(posedge ACLK); #1;
      end
      chk("b_handshake", done, 1);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge ACLK); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    cycles(1);
    chk("ready_after_reset", {AWREADY, WREADY}, 2'b11);

    // Simultaneous AW+W with exact latency checks.
    BREADY = 1'b1;
    expect_write(32'h08, 32'hDEADBEEF, 4'hF);
    AWVALID = 1'b1; AWADDR = 32'h08; WVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK); chk("t1_wr_en_cycle", {reg_wr_en, reg_wr_idx}, {1'b1, 30'd2});
    @(negedge ACLK); chk("t1_bvalid_cycle", {BVALID, BRESP, reg_wr_en}, 4'b1000);
    @(negedge ACLK); chk("t1_ready_return", {AWREADY, WREADY, BVALID}, 3'b110);
    @(posedge ACLK); #1;

    // W three cycles ahead of AW, sparse strobes, top register.
    do_write(32'h3C, 32'h11223344, 4'b0101, 3, 0, 1, 100);

    // Out-of-range address: SLVERR held while BREADY low.
    BREADY = 1'b0;
    do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0);
    cycles(1);
    repeat (5) begin @(negedge ACLK); chk("t3_bvalid_held", {BVALID, BRESP}, 3'b110); end
    @(posedge ACLK); #1; BREADY = 1'b1;
    @(posedge ACLK); #1;
    @(negedge ACLK); chk("t3_bvalid_cleared", BVALID, 0);
    @(posedge ACLK); #1;

    // Zero strobes: no pulse, OKAY.
    do_write(32'h04, 32'h55AA55AA, 4'b0000, 0, 1, 1, 100);

    // Back-to-back: second pair offered while the first is still in flight.
    BREADY = 1'b1;
    do_write(32'h20, 32'hA5A5A5A5, 4'b1001, 0, 0, 0, 100);
    do_write(32'h24, 32'h0F0F0F0F, 4'b0110, 0, 0, 1, 100);

    // Reset during RESP: response dropped.
    BREADY = 1'b0;
    do_write(32'h10, 32'h12345678, 4'hF, 0, 0, 0, 0);
    cycles(1);
    @(negedge ACLK); chk("t6_in_resp", BVALID, 1);
    @(posedge ACLK); #1;
    ARESET = 1'b1; resp_q.delete();
    cycles(2);
    ARESET = 1'b0; BREADY = 1'b1;
    cycles(4);
    chk("t6_ready_after_release", {AWREADY, WREADY, BVALID}, 3'b110);

    // Reset with only AW captured: no write, no response.
    AWVALID = 1'b1; AWADDR = 32'h14;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    @(negedge ACLK); chk("t6b_aw_captured", {AWREADY, WREADY}, 2'b01);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    cycles(2);
    ARESET = 1'b0;
    cycles(4);
    chk("t6b_ready_after_release", {AWREADY, WREADY, BVALID}, 3'b110);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = ($urandom_range(3) == 0) ? $urandom : ($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      do_write(a, $urandom, 4'($urandom_range(15)), $urandom_range(3), $urandom_range(3), 1, 60);
    end

    cycles(5);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("resp_queue_drained", resp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
